// File: rtl/axis_demux_pkg.sv
// axis_demux_pkg
//   Shared constants for the AXI-Stream packet demultiplexer.
//   - ST_*     : 2-bit FSM state encoding used by axis_pkt_demux.
//   - ROUTE_M* : header route codes that select an output port.
//   Route codes 2 and 3 have no constant. They are either dropped or
//   aliased, depending on the AXIS_DEMUX_DROP_EN build option.
package axis_demux_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_FWD0 = 2'd1;
  localparam logic [1:0] ST_FWD1 = 2'd2;
  localparam logic [1:0] ST_DROP = 2'd3;

  localparam logic [1:0] ROUTE_M0 = 2'd0;
  localparam logic [1:0] ROUTE_M1 = 2'd1;

endpackage

// File: rtl/axis_skid.sv
// axis_skid
//   Two-entry registered stream buffer. The payload is an opaque W-bit word;
//   the demux uses it for {tlast, tdata}. Both s_ready and m_valid come
//   straight from flops:
//     s_ready = not full
//     m_valid = not empty
//   This lets the buffer sit between any two stream stages without a
//   combinational path through it. FIFO order is preserved.
// Ports
//   axis_aclk, axis_aresetn : clock, asynchronous active-low reset
//   s_data/s_valid/s_ready  : upstream side
//   m_data/m_valid/m_ready  : downstream side (m_data is entry 0, the head)
module axis_skid #(
  parameter int W = 33
) (
  input  logic         axis_aclk,
  input  logic         axis_aresetn,
  input  logic [W-1:0] s_data,
  input  logic         s_valid,
  output logic         s_ready,
  output logic [W-1:0] m_data,
  output logic         m_valid,
  input  logic         m_ready
);

  logic [W-1:0] head_q, head_d;
  logic [W-1:0] tail_q, tail_d;
  logic [1:0]   count_q, count_d;
  logic         s_ready_q, s_ready_d;
  logic         m_valid_q, m_valid_d;
  logic         push, pop;

  assign push = s_valid & s_ready_q;
  assign pop  = m_valid_q & m_ready;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    case ({push, pop})
      2'b10: begin
        if (count_q == 2'd0) head_d = s_data;
        else                 tail_d = s_data;
        count_d = count_q + 2'd1;
      end
      2'b01: begin
        // Shift the second entry to the head. When only one entry was
        // present, the head keeps a stale copy, which is harmless because
        // m_valid drops.
        head_d  = tail_q;
        count_d = count_q - 2'd1;
      end
      2'b11: begin
        if (count_q == 2'd1) begin
          head_d = s_data;
        end else begin
          head_d = tail_q;
          tail_d = s_data;
        end
      end
      default: ;
    endcase
    s_ready_d = (count_d != 2'd2);
    m_valid_d = (count_d != 2'd0);
  end

  always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
    if (!axis_aresetn) begin
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= 2'd0;
      s_ready_q <= 1'b0;
      m_valid_q <= 1'b0;
    end else begin
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
      s_ready_q <= s_ready_d;
      m_valid_q <= m_valid_d;
    end
  end

  assign s_ready = s_ready_q;
  assign m_valid = m_valid_q;
  assign m_data  = head_q;

endmodule

// File: rtl/axis_pkt_demux.sv
// axis_pkt_demux
//   Packet-level AXI-Stream demultiplexer. The route field
//   tdata[ROUTE_LSB+1:ROUTE_LSB] of each header beat selects an output port.
//   The whole packet, header included, follows that port until tlast.
//   Each output is decoupled by a two-entry axis_skid. A stalled port
//   therefore only stalls the input, and the other port keeps draining.
// Build option
//   AXIS_DEMUX_DROP_EN : routes 2/3 are discarded up to tlast and counted in
//                        drop_cnt (saturating). Without it only route bit 0
//                        is decoded: routes 2/3 alias to ports 0/1, and the
//                        DROP state and the drop_cnt port do not exist.
// Ports
//   axis_aclk, axis_aresetn       : clock, asynchronous active-low reset
//   s_axis_*                      : merged input stream (tdata/tvalid/tready/tlast)
//   m0_axis_*, m1_axis_*          : route 0 / route 1 outputs
//   drop_cnt                      : dropped packet count (AXIS_DEMUX_DROP_EN only)
//
// state   | meaning
// IDLE    | next beat is a header; route decoded combinationally from it
// FWD0    | packet body locked to output 0
// FWD1    | packet body locked to output 1
// DROP    | packet body discarded (AXIS_DEMUX_DROP_EN only)
module axis_pkt_demux
  import axis_demux_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int ROUTE_LSB = 30
`ifdef AXIS_DEMUX_DROP_EN
  ,
  parameter int CNT_W     = 16
`endif
) (
  input  logic              axis_aclk,
  input  logic              axis_aresetn,
  input  logic [DATA_W-1:0] s_axis_tdata,
  input  logic              s_axis_tvalid,
  output logic              s_axis_tready,
  input  logic              s_axis_tlast,
  output logic [DATA_W-1:0] m0_axis_tdata,
  output logic              m0_axis_tvalid,
  input  logic              m0_axis_tready,
  output logic              m0_axis_tlast,
  output logic [DATA_W-1:0] m1_axis_tdata,
  output logic              m1_axis_tvalid,
  input  logic              m1_axis_tready,
  output logic              m1_axis_tlast
`ifdef AXIS_DEMUX_DROP_EN
  ,
  output logic [CNT_W-1:0]  drop_cnt
`endif
);

  logic [1:0] state_q, state_d;
  logic       sel0, sel1;
  logic       s_hs;

  logic              sk0_s_ready, sk1_s_ready;
  logic [DATA_W:0]   sk0_m_data, sk1_m_data;

`ifdef AXIS_DEMUX_DROP_EN
  logic             drop_sel;
  logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
`endif

  // Port select. In IDLE the header beat itself picks the port, so back-to-back
  // packets to different ports need no bubble.
  always_comb begin
    sel0 = 1'b0;
    sel1 = 1'b0;
`ifdef AXIS_DEMUX_DROP_EN
    drop_sel = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
`ifdef AXIS_DEMUX_DROP_EN
        if (s_axis_tdata[ROUTE_LSB+1:ROUTE_LSB] == ROUTE_M0)      sel0 = 1'b1;
        else if (s_axis_tdata[ROUTE_LSB+1:ROUTE_LSB] == ROUTE_M1) sel1 = 1'b1;
        else                                                      drop_sel = 1'b1;
`else
        sel0 = (s_axis_tdata[ROUTE_LSB] == ROUTE_M0[0]);
        sel1 = (s_axis_tdata[ROUTE_LSB] == ROUTE_M1[0]);
`endif
      end
      ST_FWD0: sel0 = 1'b1;
      ST_FWD1: sel1 = 1'b1;
`ifdef AXIS_DEMUX_DROP_EN
      ST_DROP: drop_sel = 1'b1;
`endif
      default: ;
    endcase
  end

`ifdef AXIS_DEMUX_DROP_EN
  assign s_axis_tready = (sel0 & sk0_s_ready) | (sel1 & sk1_s_ready) | drop_sel;
`else
  assign s_axis_tready = (sel0 & sk0_s_ready) | (sel1 & sk1_s_ready);
`endif

  assign s_hs = s_axis_tvalid & s_axis_tready;

  always_comb begin
    state_d = state_q;
    if (s_hs) begin
      case (state_q)
        ST_IDLE: begin
          if (!s_axis_tlast) begin
            if (sel0)      state_d = ST_FWD0;
            else if (sel1) state_d = ST_FWD1;
            else           state_d = ST_DROP;
          end
        end
        ST_FWD0, ST_FWD1, ST_DROP: begin
          if (s_axis_tlast) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
`ifndef AXIS_DEMUX_DROP_EN
    // DROP is unreachable in this build; recover to IDLE if it ever shows up.
    if (state_q == ST_DROP) state_d = ST_IDLE;
`endif
  end

`ifdef AXIS_DEMUX_DROP_EN
  // Count once per dropped packet, on its header beat, saturating at all-ones.
  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (s_hs && (state_q == ST_IDLE) && drop_sel && (drop_cnt_q != {CNT_W{1'b1}}))
      drop_cnt_d = drop_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
  end

  always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
    if (!axis_aresetn) drop_cnt_q <= '0;
    else               drop_cnt_q <= drop_cnt_d;
  end

  assign drop_cnt = drop_cnt_q;
`endif

  always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
    if (!axis_aresetn) state_q <= ST_IDLE;
    else               state_q <= state_d;
  end

  axis_skid #(.W(DATA_W + 1)) u_skid0 (
    .axis_aclk    (axis_aclk),
    .axis_aresetn (axis_aresetn),
    .s_data       ({s_axis_tlast, s_axis_tdata}),
    .s_valid      (s_axis_tvalid & sel0),
    .s_ready      (sk0_s_ready),
    .m_data       (sk0_m_data),
    .m_valid      (m0_axis_tvalid),
    .m_ready      (m0_axis_tready)
  );

  axis_skid #(.W(DATA_W + 1)) u_skid1 (
    .axis_aclk    (axis_aclk),
    .axis_aresetn (axis_aresetn),
    .s_data       ({s_axis_tlast, s_axis_tdata}),
    .s_valid      (s_axis_tvalid & sel1),
    .s_ready      (sk1_s_ready),
    .m_data       (sk1_m_data),
    .m_valid      (m1_axis_tvalid),
    .m_ready      (m1_axis_tready)
  );

  assign m0_axis_tlast = sk0_m_data[DATA_W];
  assign m0_axis_tdata = sk0_m_data[DATA_W-1:0];
  assign m1_axis_tlast = sk1_m_data[DATA_W];
  assign m1_axis_tdata = sk1_m_data[DATA_W-1:0];

endmodule

// File: tb/tb_axis_pkt_demux.sv
// tb_axis_pkt_demux
//   Testbench for axis_pkt_demux. Inputs are driven 1 time unit after the
//   rising edge and outputs are sampled on the falling edge. The expected
//   beats for each port come from a packet-level model: the route field of
//   each header decides where the whole packet goes.
module tb_axis_pkt_demux;

  logic        axis_aclk = 1'b0;
  logic        axis_aresetn = 1'b0;
  logic [31:0] s_axis_tdata = '0;
  logic        s_axis_tvalid = 1'b0;
  logic        s_axis_tready;
  logic        s_axis_tlast = 1'b0;
  logic [31:0] m0_axis_tdata, m1_axis_tdata;
  logic        m0_axis_tvalid, m1_axis_tvalid;
  logic        m0_axis_tready = 1'b1, m1_axis_tready = 1'b1;
  logic        m0_axis_tlast, m1_axis_tlast;
`ifdef AXIS_DEMUX_DROP_EN
  logic [15:0] drop_cnt;
`endif

  always #5 axis_aclk = ~axis_aclk;

  axis_pkt_demux dut (
    .axis_aclk      (axis_aclk),
    .axis_aresetn   (axis_aresetn),
    .s_axis_tdata   (s_axis_tdata),
    .s_axis_tvalid  (s_axis_tvalid),
    .s_axis_tready  (s_axis_tready),
    .s_axis_tlast   (s_axis_tlast),
    .m0_axis_tdata  (m0_axis_tdata),
    .m0_axis_tvalid (m0_axis_tvalid),
    .m0_axis_tready (m0_axis_tready),
    .m0_axis_tlast  (m0_axis_tlast),
    .m1_axis_tdata  (m1_axis_tdata),
    .m1_axis_tvalid (m1_axis_tvalid),
    .m1_axis_tready (m1_axis_tready),
    .m1_axis_tlast  (m1_axis_tlast)
`ifdef AXIS_DEMUX_DROP_EN
    ,
    .drop_cnt       (drop_cnt)
`endif
  );

  int passed = 0;
  int total  = 0;
  int cyc    = 0;

  logic [32:0] tx_q[$];
  logic [32:0] exp0[$], exp1[$];
  logic [32:0] rx0[$], rx1[$];
  int          rx0_cyc[$], rx1_cyc[$], acc_cyc[$];
  int          drop_exp = 0;
  bit          m0_seen, m1_seen;
  int          stab_viol = 0;
  bit          drv_timeout = 0;
  bit          drv_done = 0;
  bit          gaps_en = 0;
  bit          rand_on = 0;

  logic [32:0] prev0 = '0, prev1 = '0;
  logic        pv0 = 0, pr0 = 0, pv1 = 0, pr1 = 0;

  always @(posedge axis_aclk) cyc <= cyc + 1;

  // Output monitor: records every handshake and watches the hold-while-stalled rule.
  always @(negedge axis_aclk) begin
    if (axis_aresetn) begin
      if (pv0 && !pr0 && (!m0_axis_tvalid || {m0_axis_tlast, m0_axis_tdata} !== prev0)) stab_viol++;
      if (pv1 && !pr1 && (!m1_axis_tvalid || {m1_axis_tlast, m1_axis_tdata} !== prev1)) stab_viol++;
      if (m0_axis_tvalid) m0_seen = 1;
      if (m1_axis_tvalid) m1_seen = 1;
      if (m0_axis_tvalid && m0_axis_tready) begin
        rx0.push_back({m0_axis_tlast, m0_axis_tdata});
        rx0_cyc.push_back(cyc);
      end
      if (m1_axis_tvalid && m1_axis_tready) begin
        rx1.push_back({m1_axis_tlast, m1_axis_tdata});
        rx1_cyc.push_back(cyc);
      end
    end
    pv0 = m0_axis_tvalid; pr0 = m0_axis_tready; prev0 = {m0_axis_tlast, m0_axis_tdata};
    pv1 = m1_axis_tvalid; pr1 = m1_axis_tready; prev1 = {m1_axis_tlast, m1_axis_tdata};
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at time %0t, required to finish earlier", $time);
    $fatal(1);
  end

  task automatic step(input int n);
    repeat (n) @(posedge axis_aclk);
    #1;
  endtask

  function automatic void clear_obs();
    tx_q.delete(); exp0.delete(); exp1.delete();
    rx0.delete(); rx1.delete(); rx0_cyc.delete(); rx1_cyc.delete(); acc_cyc.delete();
    m0_seen = 0; m1_seen = 0;
  endfunction

  // Reference model: the header route decides the fate of the whole packet.
  function automatic void add_pkt(input logic [31:0] hdr, input int len, input bit quiet_body);
    logic [1:0]  r;
    int          port;
    logic [31:0] d;
    logic [32:0] beat;
    r = hdr[31:30];
`ifdef AXIS_DEMUX_DROP_EN
    port = (r >= 2'd2) ? -1 : int'(r);
`else
    port = int'(r[0]);
`endif
    if (port < 0) drop_exp++;
    for (int i = 0; i < len; i++) begin
      d = (i == 0) ? hdr : $urandom;
      if (quiet_body && i != 0) d[31:30] = 2'b00;
      beat = {(i == len - 1), d};
      tx_q.push_back(beat);
      if (port == 0) exp0.push_back(beat);
      else if (port == 1) exp1.push_back(beat);
    end
  endfunction

  task automatic send_beat(input logic [32:0] b);
    s_axis_tvalid = 1'b1;
    {s_axis_tlast, s_axis_tdata} = b;
    for (int t = 0; t < 500; t++) begin
      @(negedge axis_aclk);
      if (s_axis_tready) begin
        acc_cyc.push_back(cyc);
        @(posedge axis_aclk); #1;
        return;
      end
      @(posedge axis_aclk); #1;
    end
    drv_timeout = 1;
  endtask

  task automatic drive_all();
    drv_done = 0;
    while (tx_q.size() > 0 && !drv_timeout) begin
      if (gaps_en && $urandom_range(0, 3) == 0) begin
        s_axis_tvalid = 1'b0;
        step(1);
      end
      send_beat(tx_q.pop_front());
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    drv_done = 1;
  endtask

  task automatic test_reset();
    axis_aresetn = 1'b0;
    drop_exp = 0;
    @(negedge axis_aclk);
    total++; if (s_axis_tready !== 1'b0) $display("FAIL reset_tready: got %b want 0", s_axis_tready); else passed++;
    total++; if ({m0_axis_tvalid, m1_axis_tvalid} !== 2'b00) $display("FAIL reset_tvalid: got %b want 00", {m0_axis_tvalid, m1_axis_tvalid}); else passed++;
    total++; if ({m0_axis_tlast, m0_axis_tdata, m1_axis_tlast, m1_axis_tdata} !== 66'd0)
      $display("FAIL reset_tdata: got m0 %h/%b m1 %h/%b want 0", m0_axis_tdata, m0_axis_tlast, m1_axis_tdata, m1_axis_tlast); else passed++;
`ifdef AXIS_DEMUX_DROP_EN
    total++; if (drop_cnt !== 16'd0) $display("FAIL reset_drop_cnt: got %0d want 0", drop_cnt); else passed++;
`endif
    @(posedge axis_aclk); #1;
    axis_aresetn = 1'b1;
    @(negedge axis_aclk);
    total++; if (s_axis_tready !== 1'b0) $display("FAIL release_tready_early: got %b want 0", s_axis_tready); else passed++;
    @(negedge axis_aclk);
    total++; if (s_axis_tready !== 1'b1) $display("FAIL release_tready_rise: got %b want 1", s_axis_tready); else passed++;
    step(1);
  endtask

  task automatic test_single_beat();
    clear_obs();
    add_pkt(32'h0000_0001, 1, 0);
    add_pkt(32'h4000_0002, 1, 0);
    drive_all();
    step(5);
    total++; if (rx0.size() != 1 || rx0[0] !== {1'b1, 32'h0000_0001})
      $display("FAIL single_m0: got %0d beats first %h want 1 beat %h", rx0.size(), (rx0.size() > 0) ? rx0[0] : 33'd0, {1'b1, 32'h0000_0001}); else passed++;
    total++; if (rx1.size() != 1 || rx1[0] !== {1'b1, 32'h4000_0002})
      $display("FAIL single_m1: got %0d beats first %h want 1 beat %h", rx1.size(), (rx1.size() > 0) ? rx1[0] : 33'd0, {1'b1, 32'h4000_0002}); else passed++;
    total++; if (acc_cyc.size() != 2 || acc_cyc[1] - acc_cyc[0] != 1)
      $display("FAIL single_no_bubble_in: got %0d accepts want 2 in consecutive cycles", acc_cyc.size()); else passed++;
    total++; if (rx0_cyc.size() != 1 || acc_cyc.size() < 1 || rx0_cyc[0] != acc_cyc[0] + 1)
      $display("FAIL single_latency: got m0 visible cycle %0d want accept cycle + 1", (rx0_cyc.size() > 0) ? rx0_cyc[0] : -1); else passed++;
    total++; if (rx0_cyc.size() != 1 || rx1_cyc.size() != 1 || rx1_cyc[0] != rx0_cyc[0] + 1)
      $display("FAIL single_no_bubble_out: got m1 cycle minus m0 cycle %0d want 1",
               (rx0_cyc.size() > 0 && rx1_cyc.size() > 0) ? rx1_cyc[0] - rx0_cyc[0] : -1); else passed++;
  endtask

  task automatic test_route_lock();
    bit ok;
    clear_obs();
    add_pkt(32'h4000_0000, 4, 1);
    drive_all();
    step(6);
    ok = (rx1.size() == exp1.size()) && (exp1.size() == 4);
    for (int i = 0; i < rx1.size() && ok; i++) if (rx1[i] !== exp1[i]) ok = 0;
    total++; if (!ok) $display("FAIL route_lock_m1: got %0d beats want %0d matching model beats", rx1.size(), exp1.size()); else passed++;
    total++; if (m0_seen !== 1'b0) $display("FAIL route_lock_m0_quiet: got m0 valid seen %b want 0", m0_seen); else passed++;
  endtask

  task automatic test_backpressure();
    bit ok;
    clear_obs();
    m0_axis_tready = 1'b0;
    add_pkt(32'h0000_0010, 3, 0);
    add_pkt(32'h4000_0020, 2, 0);
    fork
      drive_all();
    join_none
    step(10);
    total++; if (acc_cyc.size() != 2) $display("FAIL bp_input_stall: got %0d beats accepted want 2", acc_cyc.size()); else passed++;
    total++; if (s_axis_tready !== 1'b0) $display("FAIL bp_tready_low: got %b want 0", s_axis_tready); else passed++;
    total++; if (m1_seen !== 1'b0) $display("FAIL bp_m1_quiet: got m1 valid seen %b want 0", m1_seen); else passed++;
    m0_axis_tready = 1'b1;
    for (int t = 0; t < 200 && !drv_done; t++) step(1);
    total++; if (drv_done !== 1'b1 || drv_timeout !== 1'b0)
      $display("FAIL bp_drive_done: got done %b timeout %b want 1 0", drv_done, drv_timeout); else passed++;
    step(6);
    ok = (rx0.size() == exp0.size()) && (rx1.size() == exp1.size());
    for (int i = 0; i < rx0.size() && ok; i++) if (rx0[i] !== exp0[i]) ok = 0;
    for (int i = 0; i < rx1.size() && ok; i++) if (rx1[i] !== exp1[i]) ok = 0;
    total++; if (!ok) $display("FAIL bp_order: got m0 %0d m1 %0d beats want %0d %0d matching model",
                               rx0.size(), rx1.size(), exp0.size(), exp1.size()); else passed++;
  endtask

`ifdef AXIS_DEMUX_DROP_EN
  task automatic test_drop();
    clear_obs();
    add_pkt(32'h8000_0000, 3, 0);
    add_pkt(32'h0000_0003, 1, 0);
    drive_all();
    step(5);
    total++; if (acc_cyc.size() != 4 || acc_cyc[2] - acc_cyc[0] != 2)
      $display("FAIL drop_tready: got %0d accepts want 4 with dropped beats in consecutive cycles", acc_cyc.size()); else passed++;
    total++; if (m1_seen !== 1'b0) $display("FAIL drop_m1_quiet: got m1 valid seen %b want 0", m1_seen); else passed++;
    total++; if (rx0.size() != 1 || rx0[0] !== {1'b1, 32'h0000_0003})
      $display("FAIL drop_next_pkt: got %0d m0 beats want 1 beat %h", rx0.size(), {1'b1, 32'h0000_0003}); else passed++;
    total++; if (drop_cnt !== 16'(drop_exp)) $display("FAIL drop_cnt: got %0d want %0d", drop_cnt, drop_exp); else passed++;
  endtask
`else
  task automatic test_alias();
    clear_obs();
    add_pkt(32'hC000_0005, 1, 0);
    drive_all();
    step(5);
    total++; if (rx1.size() != 1 || rx1[0] !== {1'b1, 32'hC000_0005})
      $display("FAIL alias_m1: got %0d m1 beats want 1 beat %h", rx1.size(), {1'b1, 32'hC000_0005}); else passed++;
    total++; if (m0_seen !== 1'b0) $display("FAIL alias_m0_quiet: got m0 valid seen %b want 0", m0_seen); else passed++;
  endtask
`endif

  task automatic test_random();
    bit ok0, ok1;
    clear_obs();
    for (int p = 0; p < 40; p++) add_pkt($urandom, $urandom_range(1, 5), 0);
    gaps_en = 1;
    rand_on = 1;
    fork
      begin
        while (rand_on) begin
          step(1);
          m0_axis_tready = 1'($urandom_range(0, 1));
          m1_axis_tready = 1'($urandom_range(0, 1));
        end
      end
    join_none
    drive_all();
    rand_on = 0;
    step(3);
    m0_axis_tready = 1'b1;
    m1_axis_tready = 1'b1;
    gaps_en = 0;
    step(8);
    ok0 = (rx0.size() == exp0.size());
    for (int i = 0; i < rx0.size() && ok0; i++) if (rx0[i] !== exp0[i]) ok0 = 0;
    ok1 = (rx1.size() == exp1.size());
    for (int i = 0; i < rx1.size() && ok1; i++) if (rx1[i] !== exp1[i]) ok1 = 0;
    total++; if (drv_timeout !== 1'b0) $display("FAIL rand_drive_timeout: got %b want 0", drv_timeout); else passed++;
    total++; if (!ok0) $display("FAIL rand_m0_stream: got %0d beats want %0d matching model", rx0.size(), exp0.size()); else passed++;
    total++; if (!ok1) $display("FAIL rand_m1_stream: got %0d beats want %0d matching model", rx1.size(), exp1.size()); else passed++;
    total++; if (stab_viol != 0) $display("FAIL rand_hold_stable: got %0d violations want 0", stab_viol); else passed++;
`ifdef AXIS_DEMUX_DROP_EN
    total++; if (drop_cnt !== 16'(drop_exp)) $display("FAIL rand_drop_cnt: got %0d want %0d", drop_cnt, drop_exp); else passed++;
`endif
  endtask

  task automatic test_reset_mid();
    clear_obs();
    add_pkt(32'h0000_0007, 5, 1);
    send_beat(tx_q.pop_front());
    send_beat(tx_q.pop_front());
    s_axis_tvalid = 1'b0;
    axis_aresetn = 1'b0;
    drop_exp = 0;
    @(negedge axis_aclk);
    total++; if ({m0_axis_tvalid, m1_axis_tvalid, s_axis_tready} !== 3'b000)
      $display("FAIL mid_reset_ctrl: got m0v %b m1v %b tready %b want 0 0 0", m0_axis_tvalid, m1_axis_tvalid, s_axis_tready); else passed++;
    total++; if ({m0_axis_tlast, m0_axis_tdata} !== 33'd0)
      $display("FAIL mid_reset_m0_data: got %h/%b want 0", m0_axis_tdata, m0_axis_tlast); else passed++;
    step(2);
    axis_aresetn = 1'b1;
    clear_obs();
    add_pkt(32'h4000_0009, 1, 0);
    drive_all();
    step(5);
    total++; if (rx1.size() != 1 || rx1[0] !== {1'b1, 32'h4000_0009})
      $display("FAIL mid_reset_next_hdr: got %0d m1 beats want 1 beat %h", rx1.size(), {1'b1, 32'h4000_0009}); else passed++;
    total++; if (m0_seen !== 1'b0) $display("FAIL mid_reset_m0_quiet: got m0 valid seen %b want 0", m0_seen); else passed++;
`ifdef AXIS_DEMUX_DROP_EN
    total++; if (drop_cnt !== 16'd0) $display("FAIL mid_reset_drop_cnt: got %0d want 0", drop_cnt); else passed++;
`endif
  endtask

  initial begin
    test_reset();
    test_single_beat();
    test_route_lock();
    test_backpressure();
`ifdef AXIS_DEMUX_DROP_EN
    test_drop();
`else
    test_alias();
`endif
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
